vga_capture: RTL and testbench
==============================

# vga_capture

Receive-side counterpart of the VGA timing generator. Samples active-low hsync/vsync and 8-bit RGB in the generator's 50 MHz domain, recovers pixel coordinates and a data-valid strobe, measures line length and frame height, and declares lock once timing is stable. Used for loopback self-test of the video path and as the front end of a frame-capture path.

## Interface
- HACT_START, 122: clocks from the first high hsync sample to the first active pixel
- HACT_LEN, 1024: active pixels per line
- VACT_START, 26: line index of the first active line, with line 0 being the first hsync rise after a vsync rise
- VACT_LEN, 600: active lines per frame
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..15)

- clk  in  1  system clock, 50 MHz; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- rgb_in  in  8  pixel data {blue[1:0], green[2:0], red[2:0]}
- pix_data  out  8  registered pixel data
- pix_x  out  11  column within the active area
- pix_y  out  11  row within the active area
- pix_valid  out  1  locked and inside the active window
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- line_len  out  12  last measured line period in clocks
- frame_lines  out  11  last measured lines per frame
- locked  out  1  timing stable

## Operation
- **Input stage.** hs_q, vs_q and rgb_q register the inputs. hs_qq, vs_qq and rgb_qq hold the next stage.
  - hrise = hs_q & ~hs_qq
  - vrise = vs_q & ~vs_qq
- **hpos (12 bit).**
  - Loads 0 on hrise.
  - Otherwise increments, saturating at 4095.
  - hpos = n pairs with the rgb_qq sample taken n clocks after the first high hsync sample.
- **line_len.** On hrise, line_len <= hpos + 1, which is the period between rises.
- **Line mismatch.** On hrise, a mismatch is flagged if the new value differs from the current line_len.
- **vline (11 bit).**
  - Loads 2047 on vrise.
  - On hrise: 2047 wraps to 0; any other value increments, saturating at 2046.
  - If vrise and hrise occur in the same cycle, the vrise load takes priority and the hrise increment is dropped.
- **frame_lines.** On vrise, frame_lines <= vline + 1 (11-bit wrap).
- **frame_ok.** Set to 1 at every vrise. Cleared by any line mismatch or a timeout.
- **Lock FSM.** Two states, HUNT and LOCK. locked is 1 only in LOCK.
  - At vrise, a frame is good when frame_ok = 1, the new frame_lines equals the old value, and the old value is nonzero.
  - Good frame: lock_cnt increments, saturating at LOCK_FRAMES. Reaching LOCK_FRAMES enters LOCK.
  - Bad frame: lock_cnt <= 0 and the FSM goes to HUNT.
  - A line mismatch or a timeout (hpos = 4095) forces HUNT and lock_cnt <= 0 immediately, not at the next vrise.
- **Output stage (registered from the second stage).**
  - pix_data <= rgb_qq
  - pix_x <= hpos − HACT_START
  - pix_y <= vline − VACT_START
  - Both differences are truncated to 11 bits.
  - pix_valid <= locked & (HACT_START ≤ hpos < HACT_START+HACT_LEN) & (VACT_START ≤ vline < VACT_START+VACT_LEN)
  - frame_start <= same condition as pix_valid, additionally requiring hpos = HACT_START and vline = VACT_START.
  - pix_x and pix_y are don't-care when pix_valid = 0.

## Timing
- **Reset values.**
  - All outputs 0.
  - hpos = 4095, vline = 2047, lock_cnt = 0, frame_ok = 0, FSM in HUNT.
  - Input/pipeline registers 0, with hs_q, hs_qq, vs_q and vs_qq reset to 1 so that no edge fires directly out of reset.
- **Latency.** rgb_in sampled at edge k appears on pix_data after edge k+2. pix_x, pix_y, pix_valid and frame_start are aligned with pix_data.
- **Event timing.** hrise or vrise is detected in the cycle after the first high sample. The resulting register updates occur at the following edge.
- **Acquisition with defaults and a clean 1346×666 source from reset:**
  - vrise #1 and #2 are bad frames: old frame_lines is 0 or a partial count.
  - vrise #3 sets lock_cnt = 1. vrise #4 sets lock_cnt = 2 and enters LOCK.
  - locked rises one clock after vrise #4 is detected.
- **Reset mid-frame.** Discards all state. Lock requires a fresh acquisition.
- **Unlock after a sync glitch.** locked falls one clock after the offending hrise, or after hpos reaches 4095.

## Test plan
- **Clean source.** Generator model at 1346×666: hsync low for counts 0..119, vsync low for lines 0..5, active area 242..1265 × 32..631, rgb = x^y.
  - locked rises after the 4th vsync rise.
  - line_len = 1346, frame_lines = 666.
  - Exactly 1024×600 pix_valid cycles per frame.
  - pix_data matches rgb_in delayed 2 clocks.
- **Coordinates.**
  - frame_start pulses once per frame with pix_x = 0 and pix_y = 0.
  - The last valid pixel has pix_x = 1023 and pix_y = 599.
  - pix_valid = 0 for lines 0..31 and 632..665 of the generator.
- **Line glitch.** Shorten one line to 1345 clocks while locked.
  - locked drops one clock after that line's hrise; pix_valid goes to 0.
  - Lock returns after LOCK_FRAMES + 1 further vrises: the vrise closing the glitched frame is bad, then LOCK_FRAMES good frames are needed.
- **Frame-height change.** Change the source to 667 lines while locked.
  - locked drops at the next vrise; frame_lines = 667.
  - Relock follows after 2 more good frames.
- **Loss of sync.** Hold hsync_in high for 5000 clocks.
  - hpos saturates at 4095 and locked = 0 by clock 4096.
  - No pix_valid cycles occur; line_len holds its last value.
- **Reset mid-frame.** Assert rst for one cycle at line 300.
  - All outputs are 0 on the next cycle.
  - Reacquisition takes exactly 4 vrises.

Source files
------------

// File: rtl/vga_capture.sv
// Receive side of the VGA path: samples active-low syncs and RGB, recovers
// pixel coordinates, measures line/frame timing and declares lock.
module vga_capture #(
  parameter int HACT_START  = 122,
  parameter int HACT_LEN    = 1024,
  parameter int VACT_START  = 26,
  parameter int VACT_LEN    = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  rgb_in,
  output logic [7:0]  pix_data,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked
);

  localparam logic [11:0] H_BEG      = 12'(HACT_START);
  localparam logic [11:0] H_END      = 12'(HACT_START + HACT_LEN);
  localparam logic [10:0] V_BEG      = 11'(VACT_START);
  localparam logic [10:0] V_END      = 11'(VACT_START + VACT_LEN);
  localparam logic [3:0]  LOCK_MAX   = 4'(LOCK_FRAMES);
  localparam logic [11:0] HPOS_MAX   = 12'hFFF;
  localparam logic [10:0] VLINE_IDLE = 11'h7FF;
  localparam logic [10:0] VLINE_MAX  = 11'h7FE;

  typedef enum logic {HUNT, LOCK} state_t;

  state_t      state;
  logic        hs_q, hs_qq, vs_q, vs_qq;
  logic [7:0]  rgb_q, rgb_qq;
  logic [11:0] hpos;
  logic [10:0] vline;
  logic [3:0]  lock_cnt;
  logic        frame_ok;

  logic        hrise, vrise, line_mismatch, timeout, frame_good, in_window;
  logic [11:0] line_next, x_diff;
  logic [10:0] frame_next, y_diff;
  logic [3:0]  cnt_inc;

  assign hrise         = hs_q & ~hs_qq;
  assign vrise         = vs_q & ~vs_qq;
  assign line_next     = hpos + 12'd1;
  assign line_mismatch = hrise && (line_next != line_len);
  assign timeout       = (hpos == HPOS_MAX);
  assign frame_next    = vline + 11'd1;
  assign frame_good    = frame_ok && (frame_next == frame_lines) && (frame_lines != 11'd0);
  assign cnt_inc       = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;
  assign in_window     = (hpos >= H_BEG) && (hpos < H_END) && (vline >= V_BEG) && (vline < V_END);
  assign x_diff        = hpos - H_BEG;
  assign y_diff        = vline - V_BEG;

  // Sync registers reset high so no edge is seen straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q   <= 1'b1;
      hs_qq  <= 1'b1;
      vs_q   <= 1'b1;
      vs_qq  <= 1'b1;
      rgb_q  <= 8'd0;
      rgb_qq <= 8'd0;
    end else begin
      hs_q   <= hsync_in;
      hs_qq  <= hs_q;
      vs_q   <= vsync_in;
      vs_qq  <= vs_q;
      rgb_q  <= rgb_in;
      rgb_qq <= rgb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos     <= HPOS_MAX;
      line_len <= 12'd0;
    end else if (hrise) begin
      hpos     <= 12'd0;
      line_len <= line_next;
    end else if (hpos != HPOS_MAX) begin
      hpos <= line_next;
    end
  end

  // vline idles at 2047 between vrise and the first hrise of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vline       <= VLINE_IDLE;
      frame_lines <= 11'd0;
      frame_ok    <= 1'b0;
    end else begin
      if (vrise) begin
        vline       <= VLINE_IDLE;
        frame_lines <= frame_next;
      end else if (hrise) begin
        if (vline == VLINE_IDLE)
          vline <= 11'd0;
        else if (vline != VLINE_MAX)
          vline <= frame_next;
      end
      if (vrise)
        frame_ok <= 1'b1;
      else if (line_mismatch || timeout)
        frame_ok <= 1'b0;
    end
  end

  // Line errors drop lock at once; frame-height checks act only at vrise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      lock_cnt <= 4'd0;
      locked   <= 1'b0;
    end else if (line_mismatch || timeout) begin
      state    <= HUNT;
      lock_cnt <= 4'd0;
      locked   <= 1'b0;
    end else if (vrise) begin
      if (frame_good) begin
        lock_cnt <= cnt_inc;
        if (cnt_inc == LOCK_MAX) begin
          state  <= LOCK;
          locked <= 1'b1;
        end
      end else begin
        state    <= HUNT;
        lock_cnt <= 4'd0;
        locked   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data    <= 8'd0;
      pix_x       <= 11'd0;
      pix_y       <= 11'd0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_data    <= rgb_qq;
      pix_x       <= x_diff[10:0];
      pix_y       <= y_diff;
      pix_valid   <= (state == LOCK) && in_window;
      frame_start <= (state == LOCK) && in_window && (hpos == H_BEG) && (vline == V_BEG);
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: a scaled-down sync generator pushes the
// pixels it expects to see valid; a monitor pops them as pix_valid appears.
module tb_vga_capture;

  localparam int LINE_CLKS = 64;
  localparam int HS_LOW    = 8;
  localparam int VS_LOW    = 2;
  localparam int HST       = 10;
  localparam int HLEN      = 40;
  localparam int VST       = 3;
  localparam int VLEN      = 12;
  localparam int LOCKF     = 2;
  localparam int ACT_X0    = HS_LOW + HST;
  localparam int ACT_Y0    = VS_LOW + VST;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [7:0]  rgb_in = 8'd0;
  logic [7:0]  pix_data;
  logic [10:0] pix_x, pix_y;
  logic        pix_valid, frame_start, locked;
  logic [11:0] line_len;
  logic [10:0] frame_lines;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  d;
  } pix_t;

  pix_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_valid = 0;
  int   mon_fs = 0;

  always #10 clk = ~clk;

  vga_capture #(
    .HACT_START(HST), .HACT_LEN(HLEN), .VACT_START(VST),
    .VACT_LEN(VLEN), .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .frame_start(frame_start), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    checkOutput({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    checkOutput({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    checkOutput({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    checkOutput({tag, "_line_len"}, 32'(line_len), 32'd0);
    checkOutput({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  // Drives one generator frame; lines at or below cut_line are expected valid.
  task automatic applyStimulus(input int nlines, input bit exp_valid, input int cut_line,
                               input int glitch_line, input int freeze_line, input int reset_line,
                               input bit lock_before, input bit lock_after);
    int   vbase, fsbase, pushes, pfs, len;
    pix_t e;
    vbase  = mon_valid;
    fsbase = mon_fs;
    pushes = 0;
    pfs    = 0;
    for (int line = 0; line < nlines; line++) begin
      len = (line == glitch_line) ? LINE_CLKS - 1 : LINE_CLKS;
      for (int c = 0; c < len; c++) begin
        hsync_in = (c >= HS_LOW);
        vsync_in = (line >= VS_LOW);
        rgb_in   = 8'(c ^ line);
        if (exp_valid && (cut_line < 0 || line <= cut_line) &&
            c >= ACT_X0 && c < ACT_X0 + HLEN && line >= ACT_Y0 && line < ACT_Y0 + VLEN) begin
          e.x = 11'(c - ACT_X0);
          e.y = 11'(line - ACT_Y0);
          e.d = 8'(c ^ line);
          exp_q.push_back(e);
          pushes++;
          if (c == ACT_X0 && line == ACT_Y0) pfs++;
        end
        if (line == reset_line && c == 30) rst = 1'b1;
        @(posedge clk); #1;
        if (rst) begin
          checkAllZero("midreset");
          rst = 1'b0;
        end
        if (line == VS_LOW && c == 0) checkOutput("locked_at_vrise", 32'(locked), 32'(lock_before));
        if (line == VS_LOW && c == 1) checkOutput("locked_after_vrise", 32'(locked), 32'(lock_after));
        if (glitch_line >= 0 && line == glitch_line + 1 && c == HS_LOW)
          checkOutput("locked_at_glitch_hrise", 32'(locked), 32'd1);
        if (glitch_line >= 0 && line == glitch_line + 1 && c == HS_LOW + 1)
          checkOutput("locked_after_glitch_hrise", 32'(locked), 32'd0);
        if (line == freeze_line && c == 60) begin
          for (int k = 1; k <= 5000; k++) begin
            @(posedge clk); #1;
            if (k == 4044) checkOutput("locked_before_timeout", 32'(locked), 32'd1);
            if (k == 4045) checkOutput("locked_after_timeout", 32'(locked), 32'd0);
          end
          checkOutput("line_len_held", 32'(line_len), 32'(LINE_CLKS));
        end
      end
    end
    checkOutput("frame_valid_count", 32'(mon_valid - vbase), 32'(pushes));
    checkOutput("frame_start_count", 32'(mon_fs - fsbase), 32'(pfs));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (frame_start) mon_fs++;
      if (pix_valid) begin
        mon_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pixel: got valid at x=%0d y=%0d, expected no valid at %0t",
                   pix_x, pix_y, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pix_x", 32'(pix_x), 32'(e.x));
          checkOutput("pix_y", 32'(pix_y), 32'(e.y));
          checkOutput("pix_data", 32'(pix_data), 32'(e.d));
          checkOutput("pix_frame_start", 32'(frame_start), 32'(e.x == 11'd0 && e.y == 11'd0));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] acquisition");
    applyStimulus(20, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(20, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(20, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(20, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1);
    applyStimulus(20, 1'b1, -1, -1, -1, -1, 1'b1, 1'b1);
    checkOutput("line_len", 32'(line_len), 32'(LINE_CLKS));
    checkOutput("frame_lines", 32'(frame_lines), 32'd20);

    $display("[TB] line glitch");
    applyStimulus(20, 1'b1, 8, 8, -1, -1, 1'b1, 1'b1);
    applyStimulus(20, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(20, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(20, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1);

    $display("[TB] frame height change");
    applyStimulus(21, 1'b1, -1, -1, -1, -1, 1'b1, 1'b1);
    applyStimulus(21, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0);
    checkOutput("frame_lines_changed", 32'(frame_lines), 32'd21);
    applyStimulus(21, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(21, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1);

    $display("[TB] loss of sync");
    applyStimulus(21, 1'b1, 10, -1, 10, -1, 1'b1, 1'b1);
    checkOutput("locked_after_sync_loss", 32'(locked), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(21, 1'b0, -1, -1, -1, 10, 1'b0, 1'b0);
    applyStimulus(21, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(21, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(21, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0);
    applyStimulus(21, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1);
    checkOutput("frame_lines_reacquired", 32'(frame_lines), 32'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
